// File: rtl/wb_port_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package wb_port_arb_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One queued long-latency result
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Small FIFO of long-latency writeback results awaiting the register-file port.
module wb_arb_fifo
    import wb_port_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     wdata,
    input  logic          pop,
    output wb_entry_t     rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_port_arb.sv
// Shares the single register-file write port between MEM/WB and a buffered mul/div unit.
// Define WB_ARB_STARVE_EN to add the age counter that forces a drain after STARVE_LIMIT cycles.
module wb_port_arb
    import wb_port_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DEPTH        = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pipe_we_i,
    input  logic [REG_AW-1:0] pipe_addr_i,
    input  logic [REG_DW-1:0] pipe_data_i,
    input  logic              lu_valid_i,
    input  logic [REG_AW-1:0] lu_addr_i,
    input  logic [REG_DW-1:0] lu_data_i,
    output logic              lu_ready_o,
    output logic              stall_o,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_addr_o,
    output logic [REG_DW-1:0] rf_data_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
        $error("wb_port_arb: DEPTH must be 2 or 4");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("wb_port_arb: STARVE_LIMIT must be in 1..15");
    end

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          pipe_real;
    logic          starve;
    wb_entry_t     head;
    wb_entry_t     lu_entry;

    assign pipe_real       = pipe_we_i && (pipe_addr_i != REG_ZERO);
    assign lu_ready_o      = !full;
    // Address-0 results complete the handshake but never occupy a slot
    assign push            = lu_valid_i && lu_ready_o && (lu_addr_i != REG_ZERO);
    assign lu_entry.addr   = lu_addr_i;
    assign lu_entry.data   = lu_data_i;
    assign count_next      = count + CW'(push) - CW'(pop);
    assign stall_o         = (state == DRAIN);

    wb_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata (lu_entry),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

`ifdef WB_ARB_STARVE_EN
    logic [3:0] age;
    logic [3:0] age_next;

    // Counts PEND cycles where the head waits behind the pipeline
    always_comb begin
        age_next = '0;
        if (state == PEND && !empty && !pop) begin
            age_next = age + 4'd1;
        end
    end

    assign starve = (age_next == 4'(STARVE_LIMIT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            age <= '0;
        end else begin
            age <= age_next;
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant selection and next state; grants are held off while reset is asserted
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        rf_we_o    = 1'b0;
        rf_addr_o  = '0;
        rf_data_o  = '0;

        if (!rst_i) begin
            unique case (state)
                IDLE, PEND: begin
                    if (pipe_real) begin
                        rf_we_o   = 1'b1;
                        rf_addr_o = pipe_addr_i;
                        rf_data_o = pipe_data_i;
                    end else if (!empty) begin
                        pop       = 1'b1;
                        rf_we_o   = 1'b1;
                        rf_addr_o = head.addr;
                        rf_data_o = head.data;
                    end
                end
                DRAIN: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        rf_we_o   = 1'b1;
                        rf_addr_o = head.addr;
                        rf_data_o = head.data;
                    end
                end
                default: ;
            endcase
        end

        unique case (state)
            IDLE: begin
                if (count_next != '0) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (count_next == '0) begin
                    state_next = IDLE;
                end else if (count_next == CW'(DEPTH) || starve) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (count_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_port_arb.sv
// Randomized and directed bench for wb_port_arb against a queue-based reference model.
module tb_wb_port_arb;

    localparam int unsigned DEPTH        = 2;
    localparam int unsigned STARVE_LIMIT = 4;
`ifdef WB_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        pipe_we_i = 1'b0;
    logic [4:0]  pipe_addr_i = '0;
    logic [31:0] pipe_data_i = '0;
    logic        lu_valid_i = 1'b0;
    logic [4:0]  lu_addr_i = '0;
    logic [31:0] lu_data_i = '0;
    logic        lu_ready_o;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;

    int    tests  = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model: FIFO of {addr,data}, drain flag, wait age
    logic [36:0] q[$];
    bit          draining = 1'b0;
    int          age      = 0;

    always #5 clk_i = ~clk_i;

    wb_port_arb #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .DEPTH        (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pipe_we_i   (pipe_we_i),
        .pipe_addr_i (pipe_addr_i),
        .pipe_data_i (pipe_data_i),
        .lu_valid_i  (lu_valid_i),
        .lu_addr_i   (lu_addr_i),
        .lu_data_i   (lu_data_i),
        .lu_ready_o  (lu_ready_o),
        .stall_o     (stall_o),
        .rf_we_o     (rf_we_o),
        .rf_addr_o   (rf_addr_o),
        .rf_data_o   (rf_data_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs with the model, advance the model
    task automatic step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
        bit          exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        bit          popped;
        bit          had_entries;
        @(negedge clk_i);
        pipe_we_i   = pwe;
        pipe_addr_i = pa;
        pipe_data_i = pd;
        lu_valid_i  = lv;
        lu_addr_i   = la;
        lu_data_i   = ld;
        #1;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        popped   = 1'b0;
        had_entries = (q.size() > 0);
        if (draining) begin
            if (had_entries) begin
                {exp_addr, exp_data} = q[0];
                exp_we = 1'b1;
                popped = 1'b1;
            end
        end else if (pwe && pa != 5'd0) begin
            exp_we   = 1'b1;
            exp_addr = pa;
            exp_data = pd;
        end else if (had_entries) begin
            {exp_addr, exp_data} = q[0];
            exp_we = 1'b1;
            popped = 1'b1;
        end
        check("stall", 64'(stall_o), 64'(draining));
        check("ready", 64'(lu_ready_o), 64'(q.size() < int'(DEPTH)));
        check("rf_we", 64'(rf_we_o), 64'(exp_we));
        check("rf_addr", 64'(rf_addr_o), 64'(exp_addr));
        check("rf_data", 64'(rf_data_o), 64'(exp_data));

        if (lv && q.size() < int'(DEPTH) && la != 5'd0) begin
            if (popped) void'(q.pop_front());
            q.push_back({la, ld});
        end else if (popped) begin
            void'(q.pop_front());
        end
        if (!draining && had_entries && !popped) age++;
        else age = 0;
        if (draining) draining = (q.size() != 0);
        else if (had_entries && q.size() != 0 &&
                 (q.size() == int'(DEPTH) || (STARVE_EN && age == int'(STARVE_LIMIT))))
            draining = 1'b1;
    endtask

    // Assert reset mid-cycle, confirm outputs clear without a clock edge, then release
    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        check("rst_we", 64'(rf_we_o), 64'd0);
        check("rst_addr", 64'(rf_addr_o), 64'd0);
        check("rst_data", 64'(rf_data_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        q.delete();
        draining = 1'b0;
        age      = 0;
        @(negedge clk_i);
        pipe_we_i  = 1'b0;
        lu_valid_i = 1'b0;
        rst_i      = 1'b0;
    endtask

    initial begin
        int first_stall;
        #3;
        phase = "reset";
        do_reset();
        step(0, 0, 0, 0, 0, 0);

        phase = "idle_push";
        step(0, 0, 0, 1, 5'd5, 32'hDEAD0001);
        step(0, 0, 0, 0, 0, 0);
        check("lu_addr", 64'(rf_addr_o), 64'd5);
        check("lu_data", 64'(rf_data_o), 64'hDEAD0001);
        step(0, 0, 0, 0, 0, 0);

        phase = "fill_drain";
        step(1, 5'd3, 32'h3000_0001, 1, 5'd7, 32'hA0A0_0007);
        step(1, 5'd3, 32'h3000_0002, 1, 5'd9, 32'hB0B0_0009);
        step(1, 5'd3, 32'h3000_0003, 0, 0, 0);
        check("drain1_addr", 64'(rf_addr_o), 64'd7);
        step(1, 5'd3, 32'h3000_0003, 0, 0, 0);
        check("drain2_addr", 64'(rf_addr_o), 64'd9);
        step(1, 5'd3, 32'h3000_0003, 0, 0, 0);
        check("drain_done", 64'(stall_o), 64'd0);

        phase = "pipe_r0";
        step(1, 5'd3, 32'h3000_0004, 1, 5'd11, 32'hC0C0_000B);
        step(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
        check("head_addr", 64'(rf_addr_o), 64'd11);
        step(0, 0, 0, 0, 0, 0);

        phase = "lu_r0";
        step(0, 0, 0, 1, 5'd0, 32'hEEEE_EEEE);
        step(0, 0, 0, 0, 0, 0);
        check("no_write", 64'(rf_we_o), 64'd0);

        phase = "starve";
        first_stall = 0;
        step(1, 5'd3, 32'h3000_0005, 1, 5'd12, 32'h1200_000C);
        for (int i = 1; i <= 8; i++) begin
            step(1, 5'd3, 32'h3000_0010 + 32'(i), 0, 0, 0);
            if (stall_o && first_stall == 0) first_stall = i;
        end
`ifdef WB_ARB_STARVE_EN
        check("stall_cycle", 64'(first_stall), 64'(STARVE_LIMIT + 1));
`else
        check("stall_cycle", 64'(first_stall), 64'd0);
`endif
        // Flush any leftover entry
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        phase = "rst_drain";
        step(1, 5'd3, 32'h3000_0020, 1, 5'd7, 32'h7777_0007);
        step(1, 5'd3, 32'h3000_0021, 1, 5'd8, 32'h8888_0008);
        @(posedge clk_i);
        #2;
        check("pre_rst_stall", 64'(stall_o), 64'(draining));
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        phase = "random";
        for (int n = 0; n < 600; n++) begin
            logic        pwe;
            logic [4:0]  pa;
            logic        lv;
            logic [4:0]  la;
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk_i);
                #2;
                do_reset();
            end
            pwe = ($urandom_range(0, 3) != 0);
            pa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            lv  = 1'($urandom_range(0, 1));
            la  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            step(pwe, pa, $urandom, lv, la, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
